shreg_engine: RTL

SHREG_ENGINE -- requirements
Module: shreg_engine

---
 rtl/shreg_engine.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/shreg_engine.sv
// -----------------------------------------------------------------------------
// shreg_engine
//   Configurable shift-register engine. A DEPTH-bit register can shift or
//   rotate in either direction, take parallel byte loads through a valid/ready
//   handshake, step as a Galois-free (Fibonacci) LFSR, or clear itself.
//   A shift counter pulses 'wrap' once every DEPTH shift steps, and
//   'load_done' pulses after the last byte of a full-register load.
//
//   Optional feature: define SHREG_LFSR_EN to enable the LFSR mode (110).
//   Without it, mode 110 behaves as HOLD and no LFSR logic is built.
//
// Ports
//   clk         in   1        sole clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   ena         in   1        global enable, low holds all state
//   mode        in   3        operation select
//   ser_in      in   1        serial insert bit for SHL/SHR
//   load_data   in   8        byte for parallel load
//   load_valid  in   1        load byte present
//   load_ready  out  1        load byte accepted when load_valid also high
//   tap_sel     in   TAPW     byte window select
//   tap_out     out  8        selected byte (0 when tap_sel out of range)
//   ser_out     out  1        serial exit bit for the current direction
//   wrap        out  1        one-cycle pulse after DEPTH shift steps
//   load_done   out  1        one-cycle pulse after the last byte load
// -----------------------------------------------------------------------------
module shreg_engine #(
  parameter int unsigned       DEPTH = 32,
  parameter logic [DEPTH-1:0]  POLY  = 32'h8020_0003,
  localparam int unsigned      TAPW  = ((DEPTH / 8) > 1) ? $clog2(DEPTH / 8) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [2:0]      mode,
  input  logic            ser_in,
  input  logic [7:0]      load_data,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [TAPW-1:0] tap_sel,
  output logic [7:0]      tap_out,
  output logic            ser_out,
  output logic            wrap,
  output logic            load_done
);

  localparam int unsigned NBYTES    = DEPTH / 8;
  localparam int unsigned CW        = $clog2(DEPTH);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(DEPTH - 1);
  localparam logic [TAPW-1:0] PTR_LAST  = TAPW'(NBYTES - 1);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROTL  = 3'b011,
    MODE_ROTR  = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_LFSR  = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  // Elaboration-time sanity check on the parameters; a zero tap mask could
  // never produce a useful sequence.
  if ((DEPTH < 8) || (DEPTH > 64) || ((DEPTH % 8) != 0) || (POLY == '0)) begin : g_bad_param
    $error("shreg_engine: illegal DEPTH/POLY parameter");
  end

  mode_e            mode_w;
  logic [DEPTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TAPW-1:0]  ptr_q, ptr_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             step;

  assign mode_w = mode_e'(mode);

  // Handshake is purely combinational so a producer sees ready in the
  // same cycle the mode is selected.
  assign load_ready = ena && (mode_w == MODE_LOAD);

  // Next-state logic. Any enabled non-LOAD cycle restarts the byte pointer;
  // a LOAD cycle without load_valid leaves the pointer where it was.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    wrap_d = 1'b0;
    done_d = 1'b0;
    step   = 1'b0;

    if (ena) begin
      if (mode_w != MODE_LOAD) begin
        ptr_d = '0;
      end

      case (mode_w)
        MODE_HOLD: begin
        end
        MODE_SHL: begin
          sr_d = {sr_q[DEPTH-2:0], ser_in};
          step = 1'b1;
        end
        MODE_SHR: begin
          sr_d = {ser_in, sr_q[DEPTH-1:1]};
          step = 1'b1;
        end
        MODE_ROTL: begin
          sr_d = {sr_q[DEPTH-2:0], sr_q[DEPTH-1]};
          step = 1'b1;
        end
        MODE_ROTR: begin
          sr_d = {sr_q[0], sr_q[DEPTH-1:1]};
          step = 1'b1;
        end
        MODE_LOAD: begin
          if (load_valid) begin
            sr_d[{ptr_q, 3'b000} +: 8] = load_data;
            ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
            done_d = (ptr_q == PTR_LAST);
          end
        end
        MODE_LFSR: begin
`ifdef SHREG_LFSR_EN
          // All-zero state would lock the LFSR forever; force a 1 in.
          sr_d = {sr_q[DEPTH-2:0], (sr_q == '0) ? 1'b1 : ^(sr_q & POLY)};
          step = 1'b1;
`endif
        end
        MODE_CLEAR: begin
          sr_d  = '0;
          cnt_d = '0;
        end
      endcase

      // The counter only ever needs values 0..DEPTH-1: reaching DEPTH is
      // folded into the wrap back to 0.
      if (step) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // State register; wrap and load_done are registered single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      ptr_q  <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  // Byte window read; indices past the last byte read as zero.
  always_comb begin
    tap_out = 8'h00;
    if (32'(tap_sel) < NBYTES) begin
      tap_out = sr_q[{tap_sel, 3'b000} +: 8];
    end
  end

  // Right-moving modes exit through bit 0, everything else through the MSB.
  assign ser_out   = ((mode_w == MODE_SHR) || (mode_w == MODE_ROTR)) ? sr_q[0] : sr_q[DEPTH-1];
  assign wrap      = wrap_q;
  assign load_done = done_q;

endmodule
